// File: rtl/uart_ram_pkg.sv
// Shared types and counter-width helpers for the UART-to-RAM datapath core.
package uart_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic int baud_cnt_w(input int baud_period);
    return $clog2(baud_period);
  endfunction

  function automatic int bit_cnt_w(input int addr_width);
    return $clog2(addr_width + 1);
  endfunction

endpackage

// File: rtl/uart_ram_core_if.sv
// Handshake bundle between the command FSM (master) and the datapath core (slave).
interface uart_ram_core_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] rx_data;
  logic                  rx_done;
  logic                  clr_rx_done;
  logic [ADDR_WIDTH-1:0] tx_data;
  logic                  trmt;
  logic                  tx_done;
  logic                  clr_tx_done;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    input  rx_data, rx_done, tx_done, rdata,
    output clr_rx_done, tx_data, trmt, clr_tx_done, wr, addr, wdata
  );

  modport slave (
    output rx_data, rx_done, tx_done, rdata,
    input  clr_rx_done, tx_data, trmt, clr_tx_done, wr, addr, wdata
  );
endinterface

// File: rtl/uart_ram_mem.sv
// Word-addressed RAM: synchronous write, combinational read, whole array exposed for debug.
module uart_ram_mem #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] mem_r [2**ADDR_WIDTH]
);

  // Storage array; reset clears every word
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      mem_r <= '{default: '0};
    end else if (wr) begin
      mem_r[addr] <= wdata;
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/uart_ram_rx.sv
// UART receiver: synchronized line, mid-bit sampling, start-glitch and framing-error rejection.
module uart_ram_rx
  import uart_ram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int BAUD_PERIOD = 16
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  rx,
  input  logic                  clr_rx_done,
  output logic [ADDR_WIDTH-1:0] rx_data,
  output logic                  rx_done
);

  localparam int BCW = baud_cnt_w(BAUD_PERIOD);
  localparam int NBW = bit_cnt_w(ADDR_WIDTH);
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_PERIOD - 1);
  localparam logic [BCW-1:0] BAUD_HALF = BCW'(BAUD_PERIOD / 2 - 1);
  localparam logic [NBW-1:0] BIT_LAST  = NBW'(ADDR_WIDTH - 1);

  logic                  rx_meta_r, rx_sync_r, rx_prev_r;
  uart_state_e           state_r, state_nxt_s;
  logic [BCW-1:0]        baud_r, baud_nxt_s;
  logic [NBW-1:0]        bit_r, bit_nxt_s;
  logic [ADDR_WIDTH-1:0] shift_r, shift_nxt_s, rx_data_r;
  logic                  rx_done_r, frame_ok_s, start_ok_s;

  // Two-flop synchronizer plus a history flop for falling-edge detection
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Next-state, counter and shift-register decode
  always_comb begin
    state_nxt_s = state_r;
    baud_nxt_s  = baud_r + 1'b1;
    bit_nxt_s   = bit_r;
    shift_nxt_s = shift_r;
    frame_ok_s  = 1'b0;
    start_ok_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        baud_nxt_s = '0;
        if (rx_prev_r && !rx_sync_r) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_r == BAUD_HALF) begin
          baud_nxt_s = '0;
          bit_nxt_s  = '0;
          if (rx_sync_r) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DATA;
            start_ok_s  = 1'b1;
          end
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (baud_r == BAUD_LAST) begin
          baud_nxt_s  = '0;
          shift_nxt_s = {rx_sync_r, shift_r[ADDR_WIDTH-1:1]};
          bit_nxt_s   = bit_r + 1'b1;
          if (bit_r == BIT_LAST) begin
            state_nxt_s = ST_STOP;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (baud_r == BAUD_LAST) begin
          baud_nxt_s  = '0;
          state_nxt_s = ST_IDLE;
          frame_ok_s  = rx_sync_r;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        baud_nxt_s  = '0;
      end
    endcase
  end

  // FSM state, counters and the sticky result; a completed frame beats a clear
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_r   <= ST_IDLE;
      baud_r    <= '0;
      bit_r     <= '0;
      shift_r   <= '0;
      rx_data_r <= '0;
      rx_done_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      baud_r  <= baud_nxt_s;
      bit_r   <= bit_nxt_s;
      shift_r <= shift_nxt_s;
      if (frame_ok_s) begin
        rx_data_r <= shift_r;
      end
      if (frame_ok_s) begin
        rx_done_r <= 1'b1;
      end else if (clr_rx_done || start_ok_s) begin
        rx_done_r <= 1'b0;
      end
    end
  end

  assign rx_data = rx_data_r;
  assign rx_done = rx_done_r;

endmodule

// File: rtl/uart_ram_tx.sv
// UART transmitter: accepts a request only when idle and drives a registered serial line.
module uart_ram_tx
  import uart_ram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int BAUD_PERIOD = 16
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic [ADDR_WIDTH-1:0] tx_data,
  input  logic                  trmt,
  input  logic                  clr_tx_done,
  output logic                  tx,
  output logic                  tx_done
);

  localparam int BCW = baud_cnt_w(BAUD_PERIOD);
  localparam int NBW = bit_cnt_w(ADDR_WIDTH);
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_PERIOD - 1);
  localparam logic [NBW-1:0] BIT_LAST  = NBW'(ADDR_WIDTH - 1);

  uart_state_e           state_r, state_nxt_s;
  logic [BCW-1:0]        baud_r, baud_nxt_s;
  logic [NBW-1:0]        bit_r, bit_nxt_s;
  logic [ADDR_WIDTH-1:0] shift_r, shift_nxt_s;
  logic                  tx_r, tx_nxt_s, tx_done_r, accept_s, finish_s;

  // Next-state decode; the line level is derived from the next state so tx stays registered
  always_comb begin
    state_nxt_s = state_r;
    baud_nxt_s  = baud_r + 1'b1;
    bit_nxt_s   = bit_r;
    shift_nxt_s = shift_r;
    accept_s    = 1'b0;
    finish_s    = 1'b0;
    tx_nxt_s    = 1'b1;
    case (state_r)
      ST_IDLE: begin
        baud_nxt_s = '0;
        if (trmt) begin
          accept_s    = 1'b1;
          shift_nxt_s = tx_data;
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_r == BAUD_LAST) begin
          baud_nxt_s  = '0;
          bit_nxt_s   = '0;
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (baud_r == BAUD_LAST) begin
          baud_nxt_s  = '0;
          shift_nxt_s = {1'b0, shift_r[ADDR_WIDTH-1:1]};
          bit_nxt_s   = bit_r + 1'b1;
          if (bit_r == BIT_LAST) begin
            state_nxt_s = ST_STOP;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (baud_r == BAUD_LAST) begin
          baud_nxt_s  = '0;
          state_nxt_s = ST_IDLE;
          finish_s    = 1'b1;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        baud_nxt_s  = '0;
      end
    endcase
    case (state_nxt_s)
      ST_START: tx_nxt_s = 1'b0;
      ST_DATA:  tx_nxt_s = shift_nxt_s[0];
      default:  tx_nxt_s = 1'b1;
    endcase
  end

  // FSM state, counters, line register and sticky completion flag (set wins)
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_r   <= ST_IDLE;
      baud_r    <= '0;
      bit_r     <= '0;
      shift_r   <= '0;
      tx_r      <= 1'b1;
      tx_done_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      baud_r  <= baud_nxt_s;
      bit_r   <= bit_nxt_s;
      shift_r <= shift_nxt_s;
      tx_r    <= tx_nxt_s;
      if (finish_s) begin
        tx_done_r <= 1'b1;
      end else if (accept_s || clr_tx_done) begin
        tx_done_r <= 1'b0;
      end
    end
  end

  assign tx      = tx_r;
  assign tx_done = tx_done_r;

endmodule

// File: rtl/uart_ram_core.sv
// Datapath core of the UART-to-memory bridge: one receiver, one transmitter and the RAM.
module uart_ram_core
  import uart_ram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int BAUD_PERIOD = 16
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  rx,
  output logic                  tx,
  uart_ram_core_if.slave        bus,
  output logic [DATA_WIDTH-1:0] mem_debug [2**ADDR_WIDTH]
);

  if (ADDR_WIDTH < DATA_WIDTH) begin : g_width_chk
    $error("uart_ram_core: ADDR_WIDTH (%0d) must be >= DATA_WIDTH (%0d)", ADDR_WIDTH, DATA_WIDTH);
  end
  if (BAUD_PERIOD < 4) begin : g_baud_chk
    $error("uart_ram_core: BAUD_PERIOD (%0d) must be >= 4", BAUD_PERIOD);
  end

  uart_ram_rx #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BAUD_PERIOD(BAUD_PERIOD)
  ) u_rx (
    .clk        (clk),
    .rst_l      (rst_l),
    .rx         (rx),
    .clr_rx_done(bus.clr_rx_done),
    .rx_data    (bus.rx_data),
    .rx_done    (bus.rx_done)
  );

  uart_ram_tx #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BAUD_PERIOD(BAUD_PERIOD)
  ) u_tx (
    .clk        (clk),
    .rst_l      (rst_l),
    .tx_data    (bus.tx_data),
    .trmt       (bus.trmt),
    .clr_tx_done(bus.clr_tx_done),
    .tx         (tx),
    .tx_done    (bus.tx_done)
  );

  uart_ram_mem #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk  (clk),
    .rst_l(rst_l),
    .wr   (bus.wr),
    .addr (bus.addr),
    .wdata(bus.wdata),
    .rdata(bus.rdata),
    .mem_r(mem_debug)
  );

endmodule

// File: tb/tb_uart_ram_core.sv
// Self-checking bench for uart_ram_core: scoreboard queue of expected words/bits per scenario.
module tb_uart_ram_core;

  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int BP    = 16;
  localparam int FRAME = (AW + 2) * BP;

  logic clk   = 1'b0;
  logic rst_l = 1'b0;
  logic rx    = 1'b1;
  logic tx;
  logic [DW-1:0] mem_debug [2**AW];

  uart_ram_core_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  uart_ram_core #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BAUD_PERIOD(BP)
  ) dut (
    .clk      (clk),
    .rst_l    (rst_l),
    .rx       (rx),
    .tx       (tx),
    .bus      (bus.slave),
    .mem_debug(mem_debug)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] last_rx;

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [AW-1:0] payload, input logic stop_bit);
    rx = 1'b0;
    tick(BP);
    for (int i = 0; i < AW; i++) begin
      rx = payload[i];
      tick(BP);
    end
    rx = stop_bit;
    tick(BP);
    rx = 1'b1;
  endtask

  task automatic test_reset;
    int nonzero;
    rst_l = 1'b0;
    rx = 1'b1;
    bus.clr_rx_done = 1'b0;
    bus.clr_tx_done = 1'b0;
    bus.trmt = 1'b0;
    bus.tx_data = '0;
    bus.wr = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    tick(3);
    n_checks++;
    if (tx !== 1'b1) begin n_errors++; $display("FAIL reset_tx_in_reset: got %b expected 1", tx); end
    rst_l = 1'b1;
    tick(2);
    n_checks++;
    if (tx !== 1'b1) begin n_errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_checks++;
    if (bus.rx_done !== 1'b0) begin n_errors++; $display("FAIL reset_rx_done: got %b expected 0", bus.rx_done); end
    n_checks++;
    if (bus.tx_done !== 1'b0) begin n_errors++; $display("FAIL reset_tx_done: got %b expected 0", bus.tx_done); end
    n_checks++;
    if (bus.rx_data !== 16'h0000) begin n_errors++; $display("FAIL reset_rx_data: got %h expected 0000", bus.rx_data); end
    n_checks++;
    if (bus.rdata !== 8'h00) begin n_errors++; $display("FAIL reset_rdata: got %h expected 00", bus.rdata); end
    nonzero = 0;
    for (int i = 0; i < 2**AW; i++) begin
      if (mem_debug[i] !== 8'h00) nonzero++;
    end
    n_checks++;
    if (nonzero !== 0) begin n_errors++; $display("FAIL reset_mem_clear: got %0d nonzero words expected 0", nonzero); end
  endtask

  task automatic test_rx_frame;
    logic got;
    int   lat;
    logic [AW-1:0] exp;
    got = 1'b0;
    lat = 0;
    exp_q.push_back(16'hA5C3);
    fork
      send_frame(16'hA5C3, 1'b1);
      begin
        for (int c = 1; c <= 400 && !got; c++) begin
          @(posedge clk);
          #1;
          if (bus.rx_done) begin
            got = 1'b1;
            lat = c;
          end
        end
      end
    join
    n_checks++;
    if (got !== 1'b1) begin n_errors++; $display("FAIL rx_done_timeout: got %b expected 1 within 400 cycles", got); end
    n_checks++;
    if (lat < 276 || lat > 296) begin n_errors++; $display("FAIL rx_latency: got %0d cycles expected about %0d", lat, FRAME); end
    exp = exp_q.pop_front();
    n_checks++;
    if (bus.rx_data !== exp) begin n_errors++; $display("FAIL rx_data: got %h expected %h", bus.rx_data, exp); end
    last_rx = exp;
    tick(5);
    n_checks++;
    if (bus.rx_done !== 1'b1) begin n_errors++; $display("FAIL rx_done_sticky: got %b expected 1", bus.rx_done); end
    bus.clr_rx_done = 1'b1;
    tick(1);
    bus.clr_rx_done = 1'b0;
    n_checks++;
    if (bus.rx_done !== 1'b0) begin n_errors++; $display("FAIL rx_done_clear: got %b expected 0", bus.rx_done); end
    n_checks++;
    if (bus.rx_data !== last_rx) begin n_errors++; $display("FAIL rx_data_hold: got %h expected %h", bus.rx_data, last_rx); end
  endtask

  task automatic test_rx_errors;
    logic [AW-1:0] exp;
    send_frame(16'h1234, 1'b0);
    tick(40);
    n_checks++;
    if (bus.rx_done !== 1'b0) begin n_errors++; $display("FAIL frame_err_done: got %b expected 0", bus.rx_done); end
    n_checks++;
    if (bus.rx_data !== last_rx) begin n_errors++; $display("FAIL frame_err_data: got %h expected %h", bus.rx_data, last_rx); end
    rx = 1'b0;
    tick(8);
    rx = 1'b1;
    tick(40);
    n_checks++;
    if (bus.rx_done !== 1'b0) begin n_errors++; $display("FAIL glitch_done: got %b expected 0", bus.rx_done); end
    exp_q.push_back(16'h3C5A);
    send_frame(16'h3C5A, 1'b1);
    tick(20);
    exp = exp_q.pop_front();
    n_checks++;
    if (bus.rx_done !== 1'b1) begin n_errors++; $display("FAIL after_glitch_done: got %b expected 1", bus.rx_done); end
    n_checks++;
    if (bus.rx_data !== exp) begin n_errors++; $display("FAIL after_glitch_data: got %h expected %h", bus.rx_data, exp); end
    last_rx = exp;
    bus.clr_rx_done = 1'b1;
    tick(1);
    bus.clr_rx_done = 1'b0;
  endtask

  task automatic test_tx_frame;
    logic [AW-1:0] payload;
    logic [AW-1:0] exp;
    int lows;
    payload = 16'h0042;
    bus.tx_data = payload;
    bus.trmt = 1'b1;
    exp_q.push_back(16'h0000);
    for (int i = 0; i < AW; i++) exp_q.push_back({15'd0, payload[i]});
    exp_q.push_back(16'h0001);
    tick(1);
    for (int c = 1; c <= FRAME; c++) begin
      tick(1);
      if (c % BP == BP / 2) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (tx !== exp[0]) begin n_errors++; $display("FAIL tx_bit_%0d: got %b expected %b", c / BP, tx, exp[0]); end
      end
      if (c == FRAME - 1) begin
        n_checks++;
        if (bus.tx_done !== 1'b0) begin n_errors++; $display("FAIL tx_done_early: got %b expected 0", bus.tx_done); end
      end
      if (c == FRAME) begin
        n_checks++;
        if (bus.tx_done !== 1'b1) begin n_errors++; $display("FAIL tx_done_set: got %b expected 1", bus.tx_done); end
        bus.trmt = 1'b0;
      end
    end
    lows = 0;
    for (int c = 0; c < 40; c++) begin
      tick(1);
      if (tx !== 1'b1) lows++;
    end
    n_checks++;
    if (lows !== 0) begin n_errors++; $display("FAIL tx_no_second_frame: got %0d low cycles expected 0", lows); end
    n_checks++;
    if (bus.tx_done !== 1'b1) begin n_errors++; $display("FAIL tx_done_sticky: got %b expected 1", bus.tx_done); end
    bus.clr_tx_done = 1'b1;
    tick(1);
    bus.clr_tx_done = 1'b0;
    n_checks++;
    if (bus.tx_done !== 1'b0) begin n_errors++; $display("FAIL tx_done_clear: got %b expected 0", bus.tx_done); end
  endtask

  task automatic test_ram;
    logic [AW-1:0] exp;
    bus.addr = 16'h1234;
    bus.wdata = 8'h5A;
    bus.wr = 1'b1;
    exp_q.push_back(16'h005A);
    tick(1);
    bus.wr = 1'b0;
    exp = exp_q.pop_front();
    n_checks++;
    if (bus.rdata !== exp[DW-1:0]) begin n_errors++; $display("FAIL ram_rdata: got %h expected %h", bus.rdata, exp[DW-1:0]); end
    n_checks++;
    if (mem_debug[16'h1234] !== exp[DW-1:0]) begin n_errors++; $display("FAIL ram_mem_debug: got %h expected %h", mem_debug[16'h1234], exp[DW-1:0]); end
    bus.addr = 16'h1235;
    #1;
    n_checks++;
    if (bus.rdata !== 8'h00) begin n_errors++; $display("FAIL ram_neighbour: got %h expected 00", bus.rdata); end
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] addrs [4];
    logic [AW-1:0] exp;
    addrs[0] = 16'h0000;
    addrs[1] = 16'hFFFF;
    addrs[2] = 16'h00FF;
    addrs[3] = 16'h8000;
    for (int i = 0; i < 4; i++) begin
      bus.addr = addrs[i];
      bus.wdata = 8'($urandom_range(1, 255));
      bus.wr = 1'b1;
      exp_q.push_back({8'h00, bus.wdata});
      tick(1);
    end
    bus.wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.addr = addrs[i];
      #1;
      exp = exp_q.pop_front();
      n_checks++;
      if (bus.rdata !== exp[DW-1:0]) begin n_errors++; $display("FAIL b2b_read_%0d: got %h expected %h", i, bus.rdata, exp[DW-1:0]); end
    end
  endtask

  task automatic test_reset_mid_tx;
    bus.addr = 16'h1234;
    bus.tx_data = 16'h0000;
    bus.trmt = 1'b1;
    tick(1);
    bus.trmt = 1'b0;
    tick(5 * BP + BP / 2);
    n_checks++;
    if (tx !== 1'b0) begin n_errors++; $display("FAIL mid_tx_line_low: got %b expected 0", tx); end
    rst_l = 1'b0;
    #1;
    n_checks++;
    if (tx !== 1'b1) begin n_errors++; $display("FAIL mid_tx_reset_tx: got %b expected 1", tx); end
    n_checks++;
    if (bus.tx_done !== 1'b0) begin n_errors++; $display("FAIL mid_tx_reset_done: got %b expected 0", bus.tx_done); end
    n_checks++;
    if (mem_debug[16'h1234] !== 8'h00 || mem_debug[16'hFFFF] !== 8'h00) begin
      n_errors++;
      $display("FAIL mid_tx_reset_mem: got %h/%h expected 00/00", mem_debug[16'h1234], mem_debug[16'hFFFF]);
    end
    n_checks++;
    if (bus.rdata !== 8'h00) begin n_errors++; $display("FAIL mid_tx_reset_rdata: got %h expected 00", bus.rdata); end
    tick(3);
    rst_l = 1'b1;
    tick(4 * BP);
    n_checks++;
    if (tx !== 1'b1 || bus.tx_done !== 1'b0) begin
      n_errors++;
      $display("FAIL post_reset_idle: got tx=%b tx_done=%b expected tx=1 tx_done=0", tx, bus.tx_done);
    end
  endtask

  initial begin
    last_rx = '0;
    test_reset();
    test_rx_frame();
    test_rx_errors();
    test_tx_frame();
    test_ram();
    test_back_to_back();
    test_reset_mid_tx();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: summary not reached within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
